// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Parametrised inter-stage pipeline register with a valid/ready handshake.
//   Entries are held in a two-entry buffer: a main register and a skid register.
//   The main register drives the outputs. The skid register catches the entry
//   accepted in the cycle the downstream stalls. Because of this, in_ready comes
//   straight from a flop and has no combinational path from out_ready.
//   Control bits are kept at zero whenever their entry is not valid, so a
//   bubble never has architectural effect downstream.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, the stage adds the CNT_W parameter and two saturating counters.
//   stall_cnt counts cycles with a held output that is not taken.
//   bubble_cnt counts cycles with an empty output.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      synchronous kill of all held entries; drops same-cycle input
//   in_valid   upstream offers an entry
//   in_ready   stage can accept an entry (registered)
//   in_ctrl    upstream control bits  [CTRL_W]
//   in_data    upstream payload       [DATA_W]
//   out_valid  output entry valid
//   out_ready  downstream takes the output entry
//   out_ctrl   control bits, zero whenever out_valid=0
//   out_data   payload
//   stall_cnt  stall cycle counter    [CNT_W] (PIPE_STAGE_PERF_EN only)
//   bubble_cnt bubble cycle counter   [CNT_W] (PIPE_STAGE_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DATA_W = 69
`ifdef PIPE_STAGE_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Main entry (drives the outputs) and skid entry.
  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic              r_s_valid;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic              r_in_ready;

  logic w_acc;
  logic w_deq;

  assign w_acc = in_valid & r_in_ready;
  assign w_deq = r_m_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign out_ctrl  = r_m_ctrl;
  assign out_data  = r_m_data;

  // Entry storage and ready flop. r_in_ready always tracks the inverse of the
  // next skid valid, so it matches !s_valid without a combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid  <= 1'b0;
      r_m_ctrl   <= '0;
      r_m_data   <= '0;
      r_s_valid  <= 1'b0;
      r_s_ctrl   <= '0;
      r_s_data   <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_m_valid  <= 1'b0;
      r_m_ctrl   <= '0;
      r_m_data   <= '0;
      r_s_valid  <= 1'b0;
      r_s_ctrl   <= '0;
      r_s_data   <= '0;
      r_in_ready <= 1'b1;
    end else if (!r_m_valid || w_deq) begin
      // Main frees up this cycle. The skid entry, if any, has priority.
      // While the skid is full, in_ready is 0, so acc cannot be set here.
      if (r_s_valid) begin
        r_m_valid  <= 1'b1;
        r_m_ctrl   <= r_s_ctrl;
        r_m_data   <= r_s_data;
        r_s_valid  <= 1'b0;
        r_s_ctrl   <= '0;
        r_in_ready <= 1'b1;
      end else if (w_acc) begin
        r_m_valid  <= 1'b1;
        r_m_ctrl   <= in_ctrl;
        r_m_data   <= in_data;
      end else begin
        r_m_valid  <= 1'b0;
        r_m_ctrl   <= '0;
      end
    end else if (w_acc) begin
      // Main is stalled, so the accepted entry goes into the skid.
      r_s_valid  <= 1'b1;
      r_s_ctrl   <= in_ctrl;
      r_s_data   <= in_data;
      r_in_ready <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // Saturating performance counters. They are cleared only by reset, not by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_m_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!r_m_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed per-stage registers (for example EX->MEM).
- Adds a valid/ready handshake, a 2-entry skid buffer (main + skid) so stalls do not create combinational ready paths, and a synchronous flush.
- Control bits (MemRead/MemWrite/RegWrite etc.) are kept separate from the data payload. They are forced to 0 whenever the output is not valid, so a bubble is always architecturally inert.

Parameters:
- CTRL_W, 6, width of control field; forced to 0 on bubble, flush and reset.
- DATA_W, 69, width of data payload (default = ALUOut 32 + rt 32 + Rw 5).
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries (branch/exception).
- in_valid  input  1  upstream stage presents a valid entry.
- in_ready  output  1  stage can accept an entry this cycle; driven directly from a register.
- in_ctrl  input  CTRL_W  upstream control bits.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the output entry this cycle.
- out_ctrl  output  CTRL_W  control bits; equal to 0 whenever out_valid=0.
- out_data  output  DATA_W  payload.
- stall_cnt  output  CNT_W  only with PIPE_STAGE_PERF_EN.
- bubble_cnt  output  CNT_W  only with PIPE_STAGE_PERF_EN.

Behaviour:
- Storage:
  - main register {m_valid, m_ctrl, m_data} drives the outputs directly.
  - skid register {s_valid, s_ctrl, s_data}.
- Output and ready:
  - out_valid = m_valid.
  - out_ctrl = m_ctrl, and m_ctrl is held at 0 whenever m_valid=0.
  - in_ready = !s_valid.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - deq = m_valid & out_ready.
- Reset (synchronous, highest priority): all valid bits, ctrl, data and counters go to 0. in_ready is 1 in the cycle after reset deasserts.
- Flush (next priority, applied when reset=0):
  - m_valid, s_valid, m_ctrl and s_ctrl are cleared.
  - Data registers are zeroed.
  - Any input offered in the same cycle is dropped, even if in_ready=1.
  - in_ready=1 in the next cycle.
- Normal update, evaluated at each posedge:
  - Main empty, or deq=1:
    - If s_valid, main loads from skid and skid empties.
    - Otherwise, if acc, main loads the input.
    - Otherwise main becomes empty (m_valid=0, ctrl=0; data holds its value).
  - Main full and deq=0: main holds; if acc, skid loads the input.
  - Main and skid both full with deq=1, and acc=0 because in_ready=0: skid moves to main. The input is accepted no earlier than the following cycle.
- Latency and throughput:
  - Latency is exactly 1 cycle from acc to out_valid when no stall is active.
  - Sustained throughput is 1 entry/cycle with out_ready held at 1.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data do not change.
- Ordering: entries leave in acceptance order. Nothing is duplicated or lost except on flush.
- in_ready is registered. It does not depend combinationally on out_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments in every cycle with m_valid=1 and out_ready=0.
  - bubble_cnt increments in every cycle with m_valid=0.
  - Both counters saturate at all-ones, are cleared by reset, and are not affected by flush.
- Undefined: both ports and both counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1 with ctrl=6'h2A and data=69'h1234 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_ctrl=6'h2A, out_data=69'h1234; following cycle out_valid=0, out_ctrl=0.
- Stream 10 entries (data 1..10) back-to-back with out_ready=1 -> outputs 1..10 on 10 consecutive cycles; in_ready held at 1 throughout.
- out_ready=0 while sending 3 entries (A, B, C) -> A held in main, B in skid, in_ready=0 from the cycle after B is accepted, C waits. Release out_ready -> A, B, C emitted in order and none lost.
- Main and skid full, assert flush with in_valid=1 (D) in the same cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D never appears at the output.
- Assert reset in the middle of a stall with both entries held -> next cycle all outputs 0, in_ready=1; a new entry afterwards passes through with 1-cycle latency.
- With PIPE_STAGE_PERF_EN and CNT_W=4: hold out_ready=0 with main full for 20 cycles -> stall_cnt=15 (saturated); 5 idle cycles after reset -> bubble_cnt=5.
